pipe_reg_skid: RTL and testbench

PIPE_REG_SKID -- requirements
Module: pipe_reg_skid

---
 rtl/pipe_reg_skid_if.sv | 12 +
 rtl/pipe_reg_skid.sv | 70 +++++++
 tb/tb_pipe_reg_skid.sv | 115 +++++++++++
 3 files changed

// File: rtl/pipe_reg_skid_if.sv
// pipe_reg_skid_if: valid/ready handshake bundle between upstream, pipe_reg_skid and downstream.
interface pipe_reg_skid_if #(parameter int WIDTH = 24);
  logic [0:WIDTH-1] in_data;
  logic             in_valid;
  logic             in_ready;
  logic [0:WIDTH-1] out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       count;
  modport master (output in_data, in_valid, out_ready, input in_ready, out_data, out_valid, count);
  modport slave (input in_data, in_valid, out_ready, output in_ready, out_data, out_valid, count);
endinterface

// File: rtl/pipe_reg_skid.sv
// pipe_reg_skid: two-entry skid pipeline register with fully registered handshake outputs.
// Optional flush port enabled by PIPE_REG_FLUSH_EN.
module pipe_reg_skid #(parameter int WIDTH = 24) (
  input logic clk,
  input logic rst,
`ifdef PIPE_REG_FLUSH_EN
  input logic flush,
`endif
  pipe_reg_skid_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t state, state_n;
  logic [0:WIDTH-1] main, main_n, skid, skid_n;
  logic ready, valid;
  logic [1:0] cnt;
  logic in_xfer, out_xfer;
  assign in_xfer = bus.in_valid & ready;
  assign out_xfer = valid & bus.out_ready;
  always_comb begin
    state_n = state;
    main_n = main;
    skid_n = skid;
    unique case (state)
      EMPTY: if (in_xfer) begin
        main_n = bus.in_data;
        state_n = BUSY;
      end
      BUSY: if (in_xfer && out_xfer) main_n = bus.in_data;
      else if (in_xfer) begin
        skid_n = bus.in_data;
        state_n = FULL;
      end
      else if (out_xfer) state_n = EMPTY;
      FULL: if (out_xfer) begin
        main_n = skid;
        state_n = BUSY;
      end
      default: state_n = EMPTY;
    endcase
`ifdef PIPE_REG_FLUSH_EN
    if (flush) begin
      state_n = EMPTY;
      main_n = main;
      skid_n = skid;
    end
`endif
  end
  // handshake flags are registered from the next state so no input reaches them combinationally
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      main <= '0;
      skid <= '0;
      ready <= 1'b1;
      valid <= 1'b0;
      cnt <= 2'd0;
    end else begin
      state <= state_n;
      main <= main_n;
      skid <= skid_n;
      ready <= state_n != FULL;
      valid <= state_n != EMPTY;
      cnt <= state_n == FULL ? 2'd2 : state_n == BUSY ? 2'd1 : 2'd0;
    end
  end
  assign bus.in_ready = ready;
  assign bus.out_valid = valid;
  assign bus.out_data = main;
  assign bus.count = cnt;
endmodule

// File: tb/tb_pipe_reg_skid.sv
// tb_pipe_reg_skid: directed and random checks of pipe_reg_skid against a queue model.
module tb_pipe_reg_skid;
  logic clk = 0, rst = 0, fl = 0, acc = 0;
  int checks = 0, errors = 0;
  logic [0:23] q[$];
  logic [0:23] last = '0;
  logic [0:23] seq;
  always #5 clk = ~clk;
  pipe_reg_skid_if #(.WIDTH(24)) bus();
  pipe_reg_skid #(.WIDTH(24)) dut (
    .clk(clk),
    .rst(rst),
`ifdef PIPE_REG_FLUSH_EN
    .flush(fl),
`endif
    .bus(bus)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_state();
    chk("in_ready", {31'd0, bus.in_ready}, {31'd0, q.size() < 2});
    chk("out_valid", {31'd0, bus.out_valid}, {31'd0, q.size() > 0});
    chk("count", {30'd0, bus.count}, q.size());
    chk("out_data", {8'd0, bus.out_data}, {8'd0, q.size() > 0 ? q[0] : last});
  endtask
  task automatic cyc(input logic iv, input logic [0:23] d, input logic orr, input logic f);
    logic in_x, out_x;
    bus.in_valid = iv;
    bus.in_data = d;
    bus.out_ready = orr;
    fl = f;
    #1;
    in_x = iv && q.size() < 2 && !f;
    out_x = q.size() > 0 && orr && !f;
    if (out_x) chk("deliver", {8'd0, bus.out_data}, {8'd0, q[0]});
    @(posedge clk);
    if (f) q.delete();
    else begin
      if (out_x) last = q.pop_front();
      if (in_x) q.push_back(d);
    end
    if (q.size() > 0) last = q[0];
    acc = in_x;
    #1 check_state();
    fl = 0;
  endtask
  task automatic do_reset(input logic iv, input logic orr);
    rst = 0;
    bus.in_valid = iv;
    bus.in_data = 24'h5A5A5A;
    bus.out_ready = orr;
    repeat (2) @(posedge clk);
    q.delete();
    last = '0;
    #1 check_state();
    rst = 1;
  endtask
  initial begin
    bus.in_valid = 0;
    bus.in_data = '0;
    bus.out_ready = 0;
    do_reset(0, 0);
    chk("rst_data", {8'd0, bus.out_data}, 32'h0);
    cyc(1, 24'h010101, 1, 0);
    cyc(1, 24'h020202, 1, 0);
    chk("pt_count", {30'd0, bus.count}, 32'd1);
    chk("pt_data", {8'd0, bus.out_data}, 32'h020202);
    cyc(0, 24'h0, 1, 0);
    cyc(1, 24'h010101, 0, 0);
    cyc(1, 24'h020202, 0, 0);
    chk("bp_count", {30'd0, bus.count}, 32'd2);
    chk("bp_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_data", {8'd0, bus.out_data}, 32'h010101);
    cyc(1, 24'h030303, 0, 0);
    chk("bp_hold", {8'd0, bus.out_data}, 32'h010101);
    cyc(0, 24'h0, 1, 0);
    chk("bp_second", {8'd0, bus.out_data}, 32'h020202);
    cyc(0, 24'h0, 1, 0);
    chk("bp_drain", {30'd0, bus.count}, 32'd0);
    cyc(1, 24'h111111, 0, 0);
    cyc(1, 24'hABCDEF, 1, 0);
    chk("sim_data", {8'd0, bus.out_data}, 32'hABCDEF);
    chk("sim_count", {30'd0, bus.count}, 32'd1);
    cyc(0, 24'h0, 1, 0);
    cyc(1, 24'h444444, 0, 0);
    cyc(1, 24'h555555, 0, 0);
    do_reset(1, 1);
    chk("mid_rst_data", {8'd0, bus.out_data}, 32'h0);
`ifdef PIPE_REG_FLUSH_EN
    cyc(1, 24'h666666, 0, 0);
    cyc(1, 24'h676767, 0, 0);
    cyc(1, 24'h777777, 1, 1);
    chk("fl_count", {30'd0, bus.count}, 32'd0);
    chk("fl_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("fl_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("fl_data", {8'd0, bus.out_data}, 32'h666666);
    cyc(0, 24'h0, 1, 0);
`endif
    seq = 24'h000100;
    repeat (1000) begin
      cyc(1'($urandom % 2), seq, 1'($urandom % 2), 0);
      if (acc) seq++;
    end
    repeat (3) cyc(0, 24'h0, 1, 0);
    chk("rand_drain", {30'd0, bus.count}, 32'd0);
    chk("rand_last", {8'd0, bus.out_data}, {8'd0, seq - 24'd1});
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
